// File: rtl/tour_cmd.sv
// Replays the solver's knight tour as vertical/horizontal motion commands and passes host
// commands through when idle. Define TOUR_CMD_ABORT_EN to let a host opcode 0 abort a tour.
module tour_cmd #(
    parameter int unsigned NUM_MOVES   = 24,
    parameter logic [3:0]  OPC_MOVE    = 4'b0010,
    parameter logic [3:0]  OPC_FANFARE = 4'b0011
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_tour,
    input  logic [7:0]  move,
    output logic [4:0]  mv_indx,
    input  logic [15:0] cmd_in,
    input  logic        cmd_in_rdy,
    output logic        clr_cmd_in_rdy,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic        send_resp,
    output logic [7:0]  resp,
    output logic        tour_active,
    output logic        err
);

    localparam logic [7:0] HeadN   = 8'h00;
    localparam logic [7:0] HeadW   = 8'h3F;
    localparam logic [7:0] HeadS   = 8'h7F;
    localparam logic [7:0] HeadE   = 8'hBF;
    localparam logic [4:0] LastIdx = 5'(NUM_MOVES - 1);

    typedef enum logic [2:0] {StIdle, StCmdV, StWaitV, StCmdH, StWaitH, StAdv} state_e;

    state_e      state_q;
    logic [4:0]  mv_indx_q;
    logic        err_q;

    logic        move_ok;
    logic        dx_pos, dy_pos;
    logic [1:0]  dx_mag, dy_mag;
    logic [15:0] cmd_v, cmd_h;
    logic        abort;

    assign move_ok = $onehot(move);
    assign mv_indx = mv_indx_q;
    assign err     = err_q;

    // Knight offset per move bit as {dx positive, |dx|, dy positive, |dy|}.
    always_comb begin
        {dx_pos, dx_mag, dy_pos, dy_mag} = 6'b000000;
        case (move)
            8'h01:   {dx_pos, dx_mag, dy_pos, dy_mag} = 6'b101110;
            8'h02:   {dx_pos, dx_mag, dy_pos, dy_mag} = 6'b001110;
            8'h04:   {dx_pos, dx_mag, dy_pos, dy_mag} = 6'b010101;
            8'h08:   {dx_pos, dx_mag, dy_pos, dy_mag} = 6'b010001;
            8'h10:   {dx_pos, dx_mag, dy_pos, dy_mag} = 6'b001010;
            8'h20:   {dx_pos, dx_mag, dy_pos, dy_mag} = 6'b101010;
            8'h40:   {dx_pos, dx_mag, dy_pos, dy_mag} = 6'b110001;
            8'h80:   {dx_pos, dx_mag, dy_pos, dy_mag} = 6'b110101;
            default: {dx_pos, dx_mag, dy_pos, dy_mag} = 6'b000000;
        endcase
    end

    assign cmd_v = {OPC_MOVE, dy_pos ? HeadN : HeadS, 2'b00, dy_mag};
    assign cmd_h = {OPC_FANFARE, dx_pos ? HeadE : HeadW, 2'b00, dx_mag};

`ifdef TOUR_CMD_ABORT_EN
    assign abort = (state_q != StIdle) && cmd_in_rdy && (cmd_in[15:12] == 4'b0000);
`else
    assign abort = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            mv_indx_q <= 5'd0;
            err_q     <= 1'b0;
        end else if (abort) begin
            state_q   <= StIdle;
            mv_indx_q <= 5'd0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start_tour) begin
                        mv_indx_q <= 5'd0;
                        err_q     <= 1'b0;
                        state_q   <= StCmdV;
                    end
                end
                StCmdV: begin
                    if (!move_ok) begin
                        err_q   <= 1'b1;
                        state_q <= StAdv;
                    end else if (clr_cmd_rdy) begin
                        state_q <= StWaitV;
                    end
                end
                StWaitV: if (send_resp) state_q <= StCmdH;
                StCmdH:  if (clr_cmd_rdy) state_q <= StWaitH;
                StWaitH: if (send_resp) state_q <= StAdv;
                StAdv: begin
                    if (mv_indx_q == LastIdx) begin
                        mv_indx_q <= 5'd0;
                        state_q   <= StIdle;
                    end else begin
                        mv_indx_q <= mv_indx_q + 5'd1;
                        state_q   <= StCmdV;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_comb begin
        cmd            = cmd_v;
        cmd_rdy        = 1'b0;
        clr_cmd_in_rdy = 1'b0;
        tour_active    = (state_q != StIdle);
        resp           = 8'hA5;
        case (state_q)
            StIdle: begin
                cmd            = cmd_in;
                cmd_rdy        = cmd_in_rdy & ~start_tour;
                clr_cmd_in_rdy = clr_cmd_rdy & ~start_tour;
            end
            StCmdV:  cmd_rdy = move_ok;
            StWaitV: cmd_rdy = 1'b0;
            StCmdH: begin
                cmd     = cmd_h;
                cmd_rdy = 1'b1;
            end
            StWaitH: begin
                cmd = cmd_h;
                if (mv_indx_q == LastIdx) resp = 8'h5A;
            end
            // A valid move here means this ADV followed the final WAIT_H.
            StAdv: if (mv_indx_q == LastIdx && move_ok) resp = 8'h5A;
            default: cmd_rdy = 1'b0;
        endcase
        if (abort) begin
            cmd_rdy        = 1'b0;
            clr_cmd_in_rdy = 1'b1;
        end
        if (rst) begin
            cmd_rdy        = 1'b0;
            clr_cmd_in_rdy = 1'b0;
            tour_active    = 1'b0;
            resp           = 8'hA5;
        end
    end

endmodule
